uart_autobaud: RTL and testbench

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_autobaud.sv | 128 ++++++++++++
 tb/tb_uart_autobaud.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - UART baud rate auto-detection from a 0x55 sync frame
// Measures 8 bit times between the 1st and 5th falling edges and drives the rate to a baud generator.
module uart_autobaud #(
    parameter int MaxClockRate = 100000000,
    parameter int MinBaudRate  = 9600,
    parameter int DefaultRate  = 5208,
    parameter int MinRate      = 16,
    localparam int RW = $clog2(MaxClockRate / MinBaudRate),
    localparam int CW = RW + 3
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          rx,
    input  logic          start,
    input  logic          cfgWrite,
    input  logic [RW-1:0] cfgRate,
    output logic [RW-1:0] rate,
    output logic          genReset,
    output logic          locked,
    output logic          busy,
    output logic          error
);

    typedef enum logic [2:0] {IDLE, WAIT_START, MEASURE, WAIT_STOP, APPLY} state_t;

    state_t        state, nextState;
    logic          rxMeta, rxS, rxPrev;
    logic [CW-1:0] counter, nLatch, candidate;
    logic [1:0]    edgeCnt;
    logic          fall, counterFull, candOk;

    assign fall        = rxPrev & ~rxS;
    assign counterFull = &counter;
    assign candidate   = (nLatch + CW'(4)) >> 3;
    assign candOk      = (candidate >= CW'(MinRate)) && (candidate <= CW'((1 << RW) - 1));

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
            rxPrev <= rxS;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= nextState;
    end

    // cfgWrite has priority over start while idle; both are ignored once busy
    always_comb begin
        nextState = state;
        case (state)
            IDLE:       if (!cfgWrite && start) nextState = WAIT_START;
            WAIT_START: if (fall) nextState = MEASURE;
            MEASURE: begin
                if (counterFull)                   nextState = IDLE;
                else if (fall && edgeCnt == 2'd3)  nextState = WAIT_STOP;
            end
            WAIT_STOP: begin
                if (counterFull) nextState = IDLE;
                else if (rxS)    nextState = candOk ? APPLY : IDLE;
            end
            APPLY:      nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            counter  <= '0;
            edgeCnt  <= '0;
            nLatch   <= '0;
            rate     <= RW'(DefaultRate);
            genReset <= 1'b0;
            locked   <= 1'b0;
            error    <= 1'b0;
        end else begin
            genReset <= 1'b0;
            case (state)
                IDLE: begin
                    // a back-to-back write is dropped so genReset never stretches
                    if (cfgWrite && !genReset) begin
                        rate     <= cfgRate;
                        genReset <= 1'b1;
                        locked   <= 1'b1;
                        error    <= 1'b0;
                    end else if (!cfgWrite && start) begin
                        error <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (fall) begin
                        counter <= '0;
                        edgeCnt <= '0;
                    end
                end
                MEASURE: begin
                    if (!counterFull) counter <= counter + CW'(1);
                    if (fall) begin
                        edgeCnt <= edgeCnt + 2'd1;
                        if (edgeCnt == 2'd3) nLatch <= counter + CW'(1);
                    end
                end
                WAIT_STOP: begin
                    if (!counterFull) counter <= counter + CW'(1);
                end
                default: ;
            endcase
            // rate is loaded on entry to APPLY so it is visible alongside genReset
            if (state == WAIT_STOP && nextState == APPLY) begin
                rate     <= candidate[RW-1:0];
                genReset <= 1'b1;
                locked   <= 1'b1;
            end
            if ((state == MEASURE || state == WAIT_STOP) && nextState == IDLE) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - directed bench for uart_autobaud
// Table of sync-frame detections plus hand sequences for config writes, reset and saturation.
module tb_uart_autobaud;

    logic        clk = 1'b0;
    logic        nReset;
    logic        rx, start, cfgWrite;
    logic [13:0] cfgRate;
    logic [13:0] rate;
    logic        genReset, locked, busy, error;

    logic        rx2, start2, cfgWrite2;
    logic [6:0]  cfgRate2;
    logic [6:0]  rate2;
    logic        gen2, locked2, busy2, err2;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int consec = 0;
    int glitches = 0;
    int gen2Seen = 0;
    logic        prevGen = 1'b0;
    logic [13:0] prevRate;

    typedef struct {
        int bitT;
        int extra;
        int expRate;
        int expErr;
        int expLocked;
        int expPulses;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_autobaud dut (
        .clk(clk), .nReset(nReset), .rx(rx), .start(start),
        .cfgWrite(cfgWrite), .cfgRate(cfgRate), .rate(rate),
        .genReset(genReset), .locked(locked), .busy(busy), .error(error)
    );

    uart_autobaud #(.MaxClockRate(1000000), .MinBaudRate(9600), .DefaultRate(100), .MinRate(16)) mini (
        .clk(clk), .nReset(nReset), .rx(rx2), .start(start2),
        .cfgWrite(cfgWrite2), .cfgRate(cfgRate2), .rate(rate2),
        .genReset(gen2), .locked(locked2), .busy(busy2), .error(err2)
    );

    always @(negedge clk) begin
        if (!nReset) begin
            prevGen  = 1'b0;
            prevRate = rate;
        end else begin
            if (genReset) pulses++;
            if (genReset && prevGen) consec++;
            if (rate != prevRate && !genReset) glitches++;
            if (gen2) gen2Seen++;
            prevGen  = genReset;
            prevRate = rate;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sendFrame(input int bitT, input int extra);
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (bitT + ((i == 1) ? extra : 0)) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic runDetect(input string name, input int bitT, input int extra,
                             input int expRate, input int expErr, input int expLocked, input int expPulses);
        int p0;
        int n;
        p0 = pulses;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        sendFrame(bitT, extra);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, busy, 0);
        repeat (2) @(negedge clk);
        check({name, "_rate"}, rate, expRate);
        check({name, "_error"}, error, expErr);
        check({name, "_locked"}, locked, expLocked);
        check({name, "_pulses"}, pulses - p0, expPulses);
    endtask

    initial begin
        int p0;
        int n;
        vecs[0] = '{bitT: 10,  extra: 0, expRate: 5208, expErr: 1, expLocked: 0, expPulses: 0};
        vecs[1] = '{bitT: 100, extra: 0, expRate: 100,  expErr: 0, expLocked: 1, expPulses: 1};
        vecs[2] = '{bitT: 100, extra: 3, expRate: 100,  expErr: 0, expLocked: 1, expPulses: 1};
        vecs[3] = '{bitT: 100, extra: 4, expRate: 101,  expErr: 0, expLocked: 1, expPulses: 1};
        vecs[4] = '{bitT: 200, extra: 0, expRate: 200,  expErr: 0, expLocked: 1, expPulses: 1};
        vecs[5] = '{bitT: 16,  extra: 0, expRate: 16,   expErr: 0, expLocked: 1, expPulses: 1};
        vecs[6] = '{bitT: 15,  extra: 3, expRate: 16,   expErr: 1, expLocked: 1, expPulses: 0};

        nReset = 1'b0; rx = 1'b1; start = 1'b0; cfgWrite = 1'b0; cfgRate = '0;
        rx2 = 1'b1; start2 = 1'b0; cfgWrite2 = 1'b0; cfgRate2 = '0;
        repeat (3) @(negedge clk);
        check("reset_rate", rate, 5208);
        check("reset_genReset", genReset, 0);
        check("reset_locked", locked, 0);
        check("reset_busy", busy, 0);
        check("reset_error", error, 0);
        nReset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++)
            runDetect($sformatf("vec%0d", i), vecs[i].bitT, vecs[i].extra, vecs[i].expRate,
                      vecs[i].expErr, vecs[i].expLocked, vecs[i].expPulses);

        // manual write clears the sticky error left by the last vector
        cfgRate = 14'd434; cfgWrite = 1'b1;
        @(negedge clk);
        cfgWrite = 1'b0;
        check("cfg_rate", rate, 434);
        check("cfg_genReset", genReset, 1);
        check("cfg_locked", locked, 1);
        check("cfg_error", error, 0);
        @(negedge clk);
        check("cfg_genReset_off", genReset, 0);

        cfgRate = 14'd300; cfgWrite = 1'b1; start = 1'b1;
        @(negedge clk);
        cfgWrite = 1'b0; start = 1'b0;
        check("both_rate", rate, 300);
        check("both_genReset", genReset, 1);
        check("both_busy", busy, 0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", busy, 1);
        cfgRate = 14'd77; cfgWrite = 1'b1;
        @(negedge clk);
        cfgWrite = 1'b0;
        check("busy_cfg_rate", rate, 300);
        check("busy_cfg_genReset", genReset, 0);

        // abandon a detection part-way through measurement
        rx = 1'b0; repeat (100) @(negedge clk);
        rx = 1'b1; repeat (100) @(negedge clk);
        rx = 1'b0; repeat (50) @(negedge clk);
        p0 = pulses;
        nReset = 1'b0;
        #1;
        check("midrst_rate", rate, 5208);
        check("midrst_genReset", genReset, 0);
        check("midrst_locked", locked, 0);
        check("midrst_busy", busy, 0);
        check("midrst_error", error, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_pulses", pulses - p0, 0);
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        runDetect("post_rst", 100, 0, 100, 0, 1, 1);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        rx2 = 1'b0;
        n = 0;
        while (!busy2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        while (busy2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("sat_error", err2, 1);
        check("sat_busy", busy2, 0);
        check("sat_rate", rate2, 100);
        check("sat_locked", locked2, 0);
        check("sat_window", (n >= 1024 && n <= 1032) ? 1 : 0, 1);
        check("sat_genReset", gen2Seen, 0);
        rx2 = 1'b1;

        check("genReset_consecutive", consec, 0);
        check("rate_change_without_genReset", glitches, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
